regfile_2r1w_sb: RTL

Parametrised multi-port register file with a pending-write scoreboard. It replaces one-hot per-register enables with binary addresses. It has two registered read ports (bus_a, bus_b), one write port (bus_c), optional write-to-read bypass and an optional hardwired-zero register 0. It sits between the decode/issue stage and the ALU. The scoreboard tells issue logic which registers await an in-flight result.

---
 rtl/regfile_pkg.sv | 41 ++++
 rtl/regfile_scoreboard.sv | 83 ++++++++
 rtl/regfile_2r1w_sb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file with scoreboard:
// default sizes, the address type and the address qualification helpers.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;

    // Widest address any legal configuration can produce (NUM_REGS <= 256).
    localparam int MAX_ADDR_W = 8;

    typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] reg_addr_t;

    // Classification of an address against a register file of num_regs entries.
    typedef struct packed {
        logic legal;    // address names an existing register
        logic is_zero;  // address is register 0
    } addr_qual_t;

    function automatic addr_qual_t qualify_addr(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           num_regs
    );
        addr_qual_t q;
        q.legal   = (32'(addr) < num_regs);
        q.is_zero = (addr == {MAX_ADDR_W{1'b0}});
        return q;
    endfunction

    // An address is usable for reads, writes and claims only when it is legal
    // and is not the hardwired zero register.
    function automatic logic addr_usable(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           num_regs,
        input logic                  zero_reg
    );
        addr_qual_t q;
        q = qualify_addr(addr, num_regs);
        return q.legal & ~(zero_reg & q.is_zero);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by an issue-time claim
// and cleared by the write-back of that register. A claim on the same edge as
// a write to the same register wins, since a newer producer is now in flight.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NUM_REGS = DEFAULT_NUM_REGS,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset_all,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                claim_en,
    input  logic [ADDR_W-1:0]   claim_addr,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic                busy_a,
    output logic                busy_b,
    output logic [NUM_REGS-1:0] pending_mask
);

    logic                wr_ok_s;
    logic                claim_ok_s;
    logic                rd_ok_a_s;
    logic                rd_ok_b_s;
    logic                fwd_a_s;
    logic                fwd_b_s;
    logic [NUM_REGS-1:0] pending_next_s;

    // Qualify every incoming address against the array size and register 0.
    always_comb begin
        wr_ok_s    = wr_en    & addr_usable(MAX_ADDR_W'(wr_addr),    NUM_REGS, ZERO_REG);
        claim_ok_s = claim_en & addr_usable(MAX_ADDR_W'(claim_addr), NUM_REGS, ZERO_REG);
        rd_ok_a_s  = addr_usable(MAX_ADDR_W'(rd_addr_a), NUM_REGS, ZERO_REG);
        rd_ok_b_s  = addr_usable(MAX_ADDR_W'(rd_addr_b), NUM_REGS, ZERO_REG);
    end

    // Per-register next state: claim has priority over the clearing write.
    always_comb begin
        pending_next_s = pending_mask;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (claim_ok_s && (claim_addr == ADDR_W'(r))) begin
                pending_next_s[r] = 1'b1;
            end else if (wr_ok_s && (wr_addr == ADDR_W'(r))) begin
                pending_next_s[r] = 1'b0;
            end else begin
                pending_next_s[r] = pending_mask[r];
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            pending_mask <= {NUM_REGS{1'b0}};
        end else begin
            pending_mask <= pending_next_s;
        end
    end

    // Busy flags: a pending operand stops being busy in the cycle its result
    // is written when that result can be forwarded to the read port.
    always_comb begin
        fwd_a_s = BYPASS & wr_ok_s & (wr_addr == rd_addr_a);
        fwd_b_s = BYPASS & wr_ok_s & (wr_addr == rd_addr_b);
        busy_a  = 1'b0;
        busy_b  = 1'b0;
        if (rd_ok_a_s) begin
            busy_a = pending_mask[rd_addr_a] & ~fwd_a_s;
        end else begin
            busy_a = 1'b0;
        end
        if (rd_ok_b_s) begin
            busy_b = pending_mask[rd_addr_b] & ~fwd_b_s;
        end else begin
            busy_b = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file with two registered read ports, one write port, optional
// write-to-read bypass, optional hardwired-zero register 0, and a pending-write
// scoreboard used by issue logic to detect operands still in flight.
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = DEFAULT_DATA_W,
    parameter int  NUM_REGS = DEFAULT_NUM_REGS,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset_all,
    input  logic                rd_en_a,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic                rd_en_b,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   bus_a,
    output logic [DATA_W-1:0]   bus_b,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   bus_c,
    input  logic                claim_en,
    input  logic [ADDR_W-1:0]   claim_addr,
    output logic                busy_a,
    output logic                busy_b,
    output logic [NUM_REGS-1:0] pending_mask
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              wr_ok_s;
    logic              rd_ok_a_s;
    logic              rd_ok_b_s;
    logic [DATA_W-1:0] rd_data_a_s;
    logic [DATA_W-1:0] rd_data_b_s;

    // Address qualification for the storage ports.
    always_comb begin
        wr_ok_s   = wr_en & addr_usable(MAX_ADDR_W'(wr_addr),   NUM_REGS, ZERO_REG);
        rd_ok_a_s = addr_usable(MAX_ADDR_W'(rd_addr_a), NUM_REGS, ZERO_REG);
        rd_ok_b_s = addr_usable(MAX_ADDR_W'(rd_addr_b), NUM_REGS, ZERO_REG);
    end

    // Storage array; register 0 is never written when it is hardwired to zero,
    // so it keeps its reset value and needs no special read handling below.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_r[r] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wr_addr] <= bus_c;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Port A read mux: illegal/zero addresses read 0, same-edge write forwards.
    always_comb begin
        rd_data_a_s = {DATA_W{1'b0}};
        if (!rd_ok_a_s) begin
            rd_data_a_s = {DATA_W{1'b0}};
        end else if (BYPASS && wr_ok_s && (wr_addr == rd_addr_a)) begin
            rd_data_a_s = bus_c;
        end else begin
            rd_data_a_s = regs_r[rd_addr_a];
        end
    end

    // Port B read mux, identical to port A.
    always_comb begin
        rd_data_b_s = {DATA_W{1'b0}};
        if (!rd_ok_b_s) begin
            rd_data_b_s = {DATA_W{1'b0}};
        end else if (BYPASS && wr_ok_s && (wr_addr == rd_addr_b)) begin
            rd_data_b_s = bus_c;
        end else begin
            rd_data_b_s = regs_r[rd_addr_b];
        end
    end

    // Read output registers: load on request, otherwise hold the last value.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            bus_a <= {DATA_W{1'b0}};
            bus_b <= {DATA_W{1'b0}};
        end else begin
            if (rd_en_a) begin
                bus_a <= rd_data_a_s;
            end else begin
                bus_a <= bus_a;
            end
            if (rd_en_b) begin
                bus_b <= rd_data_b_s;
            end else begin
                bus_b <= bus_b;
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk          (clk),
        .reset_all    (reset_all),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .claim_en     (claim_en),
        .claim_addr   (claim_addr),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .busy_a       (busy_a),
        .busy_b       (busy_b),
        .pending_mask (pending_mask)
    );

endmodule
